// File: rtl/rr_arbiter_n_if.sv
// Request/grant bundle between the competing virtual channels and one
// output-port round-robin arbiter.
interface rr_arbiter_n_if #(
    parameter int N = 4
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]     req;
    logic [N-1:0]     tail;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_any;

    // The requesters drive req/tail; the arbiter drives the grant side.
    modport master (
        output req,
        output tail,
        input  gnt,
        input  gnt_idx,
        input  gnt_any
    );

    modport slave (
        input  req,
        input  tail,
        output gnt,
        output gnt_idx,
        output gnt_any
    );
endinterface

// File: rtl/rr_arbiter_n.sv
// N-requester round-robin arbiter with registered one-hot grant, encoded
// grant index and optional packet lock released by tail or by dropping req.
module rr_arbiter_n #(
    parameter int N       = 4,
    parameter bit LOCK_EN = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    rr_arbiter_n_if.slave arb
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]     gnt_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] ptr_q;

    logic [N-1:0]     gnt_d;
    logic [IDX_W-1:0] idx_d;
    logic [IDX_W-1:0] ptr_d;

    logic             locked;
    logic             found;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] cand_idx;
    int               cand;

    // Holder keeps the grant while it still requests and has not shown its tail.
    assign locked = LOCK_EN && (gnt_q != '0) && arb.req[idx_q] && !arb.tail[idx_q];

    // Circular scan starting at ptr; the wrap is explicit so N need not be a power of two.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDX_W'(cand);
            if (!found && arb.req[cand_idx]) begin
                found = 1'b1;
                win   = cand_idx;
            end
        end
    end

    always_comb begin
        gnt_d = gnt_q;
        idx_d = idx_q;
        ptr_d = ptr_q;
        if (locked) begin
            gnt_d = gnt_q;
        end else if (found) begin
            gnt_d      = '0;
            gnt_d[win] = 1'b1;
            idx_d      = win;
            if (int'(win) == N - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = win + IDX_W'(1);
            end
        end else begin
            gnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_q <= '0;
            idx_q <= '0;
            ptr_q <= '0;
        end else begin
            gnt_q <= gnt_d;
            idx_q <= idx_d;
            ptr_q <= ptr_d;
        end
    end

    assign arb.gnt     = gnt_q;
    assign arb.gnt_idx = idx_q;
    assign arb.gnt_any = |gnt_q;
endmodule

// File: tb/tb_rr_arbiter_n.sv
// Bench for rr_arbiter_n: four instances (N=4 free-running, N=4 locking,
// N=5 free-running, N=1) checked against scoreboarded expected grants.
module tb_rr_arbiter_n;
    logic clk;
    logic reset;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [4:0] gnt;
        logic [2:0] idx;
    } exp_t;

    exp_t exp_q[$];

    rr_arbiter_n_if #(.N(4)) if0 ();
    rr_arbiter_n_if #(.N(4)) if1 ();
    rr_arbiter_n_if #(.N(5)) if2 ();
    rr_arbiter_n_if #(.N(1)) if3 ();

    rr_arbiter_n #(.N(4), .LOCK_EN(1'b0)) d0 (.clk(clk), .reset(reset), .arb(if0));
    rr_arbiter_n #(.N(4), .LOCK_EN(1'b1)) d1 (.clk(clk), .reset(reset), .arb(if1));
    rr_arbiter_n #(.N(5), .LOCK_EN(1'b0)) d2 (.clk(clk), .reset(reset), .arb(if2));
    rr_arbiter_n #(.N(1), .LOCK_EN(1'b1)) d3 (.clk(clk), .reset(reset), .arb(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [4:0] g, input logic [2:0] i);
        exp_t e;
        e.gnt = g;
        e.idx = i;
        return e;
    endfunction

    // Leaves every instance freshly reset, inputs idle, at a falling edge.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        if0.req = '0; if0.tail = '0;
        if1.req = '0; if1.tail = '0;
        if2.req = '0; if2.tail = '0;
        if3.req = '0; if3.tail = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        @(negedge clk);
        reset   = 1'b0;
        if0.req = 4'b1111;
        if1.req = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            exp_q.push_back(mk(5'b0, 3'd0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests_run += 3;
            if (if0.gnt !== e.gnt[3:0]) begin
                tests_failed++;
                $display("[TB] FAIL reset_gnt[%0d]: got %b expected %b", c, if0.gnt, e.gnt[3:0]);
            end
            if (if0.gnt_idx !== e.idx[1:0]) begin
                tests_failed++;
                $display("[TB] FAIL reset_idx[%0d]: got %0d expected %0d", c, if0.gnt_idx, e.idx[1:0]);
            end
            if (if1.gnt_any !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_any[%0d]: got %b expected 0", c, if1.gnt_any);
            end
            @(negedge clk);
        end
        reset = 1'b1;
        exp_q.push_back(mk(5'b00001, 3'd0));
        @(posedge clk); #1;
        e = exp_q.pop_front();
        tests_run += 2;
        if (if0.gnt !== e.gnt[3:0]) begin
            tests_failed++;
            $display("[TB] FAIL release_gnt_d0: got %b expected %b", if0.gnt, e.gnt[3:0]);
        end
        if (if1.gnt !== e.gnt[3:0]) begin
            tests_failed++;
            $display("[TB] FAIL release_gnt_d1: got %b expected %b", if1.gnt, e.gnt[3:0]);
        end
    endtask

    task automatic test_rotation();
        exp_t e;
        logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] ids [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        if0.req = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            exp_q.push_back(mk({1'b0, seq[c]}, {1'b0, ids[c]}));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests_run += 2;
            if (if0.gnt !== e.gnt[3:0]) begin
                tests_failed++;
                $display("[TB] FAIL rot_gnt[%0d]: got %b expected %b", c, if0.gnt, e.gnt[3:0]);
            end
            if (if0.gnt_idx !== e.idx[1:0]) begin
                tests_failed++;
                $display("[TB] FAIL rot_idx[%0d]: got %0d expected %0d", c, if0.gnt_idx, e.idx[1:0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_packet_lock();
        exp_t e;
        do_reset();
        if1.req = 4'b0011;
        for (int k = 1; k <= 8; k++) begin
            if1.tail = (k == 5) ? 4'b0001 : 4'b0000;
            if (k <= 4) exp_q.push_back(mk(5'b00001, 3'd0));
            else        exp_q.push_back(mk(5'b00010, 3'd1));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests_run += 2;
            if (if1.gnt !== e.gnt[3:0]) begin
                tests_failed++;
                $display("[TB] FAIL lock_gnt[%0d]: got %b expected %b", k, if1.gnt, e.gnt[3:0]);
            end
            if (if1.gnt_idx !== e.idx[1:0]) begin
                tests_failed++;
                $display("[TB] FAIL lock_idx[%0d]: got %0d expected %0d", k, if1.gnt_idx, e.idx[1:0]);
            end
            @(negedge clk);
        end
        if1.tail = '0;
    endtask

    task automatic test_lock_drop();
        exp_t e;
        logic [3:0] rq [4] = '{4'b0100, 4'b0100, 4'b1001, 4'b1001};
        logic [3:0] tl [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000};
        logic [3:0] eg [4] = '{4'b0100, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            if1.req  = rq[c];
            if1.tail = tl[c];
            exp_q.push_back(mk({1'b0, eg[c]}, 3'd0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests_run++;
            if (if1.gnt !== e.gnt[3:0]) begin
                tests_failed++;
                $display("[TB] FAIL drop_gnt[%0d]: got %b expected %b", c, if1.gnt, e.gnt[3:0]);
            end
            @(negedge clk);
        end
        if1.tail = '0;
    endtask

    task automatic test_wrap();
        exp_t e;
        logic [4:0] rq [7] = '{5'b10001, 5'b10001, 5'b10001, 5'b00000, 5'b10001, 5'b00000, 5'b10001};
        logic [4:0] eg [7] = '{5'b00001, 5'b10000, 5'b00001, 5'b00000, 5'b10000, 5'b00000, 5'b00001};
        logic [2:0] ei [7] = '{3'd0, 3'd4, 3'd0, 3'd0, 3'd4, 3'd4, 3'd0};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            if2.req = rq[c];
            exp_q.push_back(mk(eg[c], ei[c]));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests_run += 3;
            if (if2.gnt !== e.gnt) begin
                tests_failed++;
                $display("[TB] FAIL wrap_gnt[%0d]: got %b expected %b", c, if2.gnt, e.gnt);
            end
            if (if2.gnt_idx !== e.idx) begin
                tests_failed++;
                $display("[TB] FAIL wrap_idx[%0d]: got %0d expected %0d", c, if2.gnt_idx, e.idx);
            end
            if (if2.gnt_any !== (e.gnt != 5'b0)) begin
                tests_failed++;
                $display("[TB] FAIL wrap_any[%0d]: got %b expected %b", c, if2.gnt_any, (e.gnt != 5'b0));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        do_reset();
        if1.req = 4'b1000;
        for (int c = 0; c < 2; c++) begin
            exp_q.push_back(mk(5'b01000, 3'd3));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests_run++;
            if (if1.gnt !== e.gnt[3:0]) begin
                tests_failed++;
                $display("[TB] FAIL midrst_hold[%0d]: got %b expected %b", c, if1.gnt, e.gnt[3:0]);
            end
            @(negedge clk);
        end
        if1.req = 4'b1010;
        reset   = 1'b0;
        exp_q.push_back(mk(5'b0, 3'd0));
        #1;
        e = exp_q.pop_front();
        tests_run += 3;
        if (if1.gnt !== e.gnt[3:0]) begin
            tests_failed++;
            $display("[TB] FAIL midrst_async_gnt: got %b expected %b", if1.gnt, e.gnt[3:0]);
        end
        if (if1.gnt_idx !== e.idx[1:0]) begin
            tests_failed++;
            $display("[TB] FAIL midrst_async_idx: got %0d expected %0d", if1.gnt_idx, e.idx[1:0]);
        end
        if (if1.gnt_any !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_async_any: got %b expected 0", if1.gnt_any);
        end
        #2;
        reset = 1'b1;
        exp_q.push_back(mk(5'b00010, 3'd1));
        @(posedge clk); #1;
        e = exp_q.pop_front();
        tests_run += 2;
        if (if1.gnt !== e.gnt[3:0]) begin
            tests_failed++;
            $display("[TB] FAIL midrst_after_gnt: got %b expected %b", if1.gnt, e.gnt[3:0]);
        end
        if (if1.gnt_idx !== e.idx[1:0]) begin
            tests_failed++;
            $display("[TB] FAIL midrst_after_idx: got %0d expected %0d", if1.gnt_idx, e.idx[1:0]);
        end
        @(negedge clk);
        if1.req = '0;
    endtask

    task automatic test_single();
        exp_t e;
        logic rq [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            if3.req[0] = rq[c];
            exp_q.push_back(mk({4'b0, rq[c]}, 3'd0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests_run += 2;
            if (if3.gnt !== e.gnt[0:0]) begin
                tests_failed++;
                $display("[TB] FAIL single_gnt[%0d]: got %b expected %b", c, if3.gnt, e.gnt[0]);
            end
            if (if3.gnt_idx !== e.idx[0:0]) begin
                tests_failed++;
                $display("[TB] FAIL single_idx[%0d]: got %0d expected %0d", c, if3.gnt_idx, e.idx[0]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b0;
        if0.req = '0; if0.tail = '0;
        if1.req = '0; if1.tail = '0;
        if2.req = '0; if2.tail = '0;
        if3.req = '0; if3.tail = '0;
        test_reset();
        test_rotation();
        test_packet_lock();
        test_lock_drop();
        test_wrap();
        test_mid_reset();
        test_single();
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
